// File: rtl/wavelet_accelerator_pkg.sv
// Shared types and helpers for the wavelet accelerator byte-to-word collector.
package wavelet_accelerator_pkg;

  localparam int BYTES_PER_WORD = 4;

  typedef enum logic [1:0] {
    FILL,
    STALL,
    FLUSH
  } collector_state_t;

  // Contiguous low-byte mask for a word holding cnt bytes; cnt 0 yields no valid bytes.
  function automatic logic [3:0] mask_from_count(input logic [2:0] cnt);
    case (cnt)
      3'd1:    return 4'b0001;
      3'd2:    return 4'b0011;
      3'd3:    return 4'b0111;
      3'd4:    return 4'b1111;
      default: return 4'b0000;
    endcase
  endfunction

endpackage

// File: rtl/wavelet_accelerator_data_collector_if.sv
// Byte-in / word-out handshake bundle for the data collector.
interface wavelet_accelerator_data_collector_if #(
  parameter int OUTPUT_WIDTH = 32,
  parameter int PACKET_WIDTH = 8
);

  logic                    byte_valid;
  logic [PACKET_WIDTH-1:0] byte_in;
  logic                    byte_ready;
  logic                    flush;
  logic                    word_valid;
  logic                    word_ready;
  logic [OUTPUT_WIDTH-1:0] word_out;
  logic [3:0]              word_mask;
  logic                    busy;

  modport master (
    output byte_valid, byte_in, flush, word_ready,
    input  byte_ready, word_valid, word_out, word_mask, busy
  );

  modport slave (
    input  byte_valid, byte_in, flush, word_ready,
    output byte_ready, word_valid, word_out, word_mask, busy
  );

endinterface

// File: rtl/register.sv
// Generic load-enabled register with asynchronous active-high clear.
module register #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_data,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] data_out
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      data_out <= '0;
    else if (load_data)
      data_out <= data_in;
  end

endmodule

// File: rtl/wavelet_accelerator_data_collector.sv
// Packs the 8-bit packet stream into 32-bit little-endian words, with one word in
// assembly and one in an output holding slot; flush emits a masked partial word.
module wavelet_accelerator_data_collector
  import wavelet_accelerator_pkg::*;
#(
  parameter int OUTPUT_WIDTH = 32,
  parameter int PACKET_WIDTH = 8
) (
  input logic clk,
  input logic rst,
  wavelet_accelerator_data_collector_if.slave bus
);

  collector_state_t          state, next_state;
  logic [OUTPUT_WIDTH-1:0]   asm_data, next_asm_data, eff_data;
  logic [2:0]                asm_cnt, next_asm_cnt, eff_cnt;
  logic                      byte_accept;
  logic                      slot_free;
  logic                      load_slot;
  logic [OUTPUT_WIDTH-1:0]   load_word;
  logic [3:0]                load_mask;
  logic [OUTPUT_WIDTH+3:0]   slot_q;
  logic                      word_valid_q;

  // byte_ready comes from the state register only, never from word_ready.
  assign byte_accept = bus.byte_valid && (state == FILL);
  assign slot_free   = !word_valid_q || bus.word_ready;

  // The assembly view including a byte accepted this cycle; flush sees this view.
  always_comb begin
    eff_data = asm_data;
    if (byte_accept)
      eff_data[PACKET_WIDTH*int'(asm_cnt[1:0]) +: PACKET_WIDTH] = bus.byte_in;
    eff_cnt = asm_cnt + {2'b00, byte_accept};
  end

  always_comb begin
    next_state    = state;
    next_asm_data = eff_data;
    next_asm_cnt  = eff_cnt;
    load_slot     = 1'b0;
    load_word     = eff_data;
    load_mask     = mask_from_count(eff_cnt);
    case (state)
      FILL: begin
        if (eff_cnt == 3'(BYTES_PER_WORD) || (bus.flush && eff_cnt != 3'd0)) begin
          if (slot_free) begin
            load_slot     = 1'b1;
            next_asm_data = '0;
            next_asm_cnt  = '0;
          end else if (eff_cnt == 3'(BYTES_PER_WORD)) begin
            next_state = STALL;
          end else begin
            next_state = FLUSH;
          end
        end
      end
      STALL, FLUSH: begin
        if (slot_free) begin
          load_slot     = 1'b1;
          next_asm_data = '0;
          next_asm_cnt  = '0;
          next_state    = FILL;
        end
      end
      default: next_state = FILL;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= FILL;
      asm_data <= '0;
      asm_cnt  <= '0;
    end else begin
      state    <= next_state;
      asm_data <= next_asm_data;
      asm_cnt  <= next_asm_cnt;
    end
  end

  // A load in the same cycle as a drain keeps word_valid high with the new word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      word_valid_q <= 1'b0;
    else if (load_slot)
      word_valid_q <= 1'b1;
    else if (bus.word_ready)
      word_valid_q <= 1'b0;
  end

  register #(
    .WIDTH(OUTPUT_WIDTH + 4)
  ) u_slot (
    .clk      (clk),
    .rst      (rst),
    .load_data(load_slot),
    .data_in  ({load_mask, load_word}),
    .data_out (slot_q)
  );

  assign bus.byte_ready = (state == FILL);
  assign bus.word_valid = word_valid_q;
  assign bus.word_out   = slot_q[OUTPUT_WIDTH-1:0];
  assign bus.word_mask  = slot_q[OUTPUT_WIDTH +: 4];
  assign bus.busy       = (asm_cnt != 3'd0) || (state == FLUSH) || word_valid_q;

endmodule

// File: tb/tb_wavelet_accelerator_data_collector.sv
// Directed self-checking bench for the collector: packing, stalls, flush and reset.
module tb_wavelet_accelerator_data_collector;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  wavelet_accelerator_data_collector_if #(.OUTPUT_WIDTH(32), .PACKET_WIDTH(8)) bus ();

  wavelet_accelerator_data_collector #(
    .OUTPUT_WIDTH(32),
    .PACKET_WIDTH(8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Advance one clock edge; inputs change and outputs are sampled 1 ns after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Offer one byte that must be accepted at the next edge.
  task automatic apply_stimulus(input logic [7:0] b);
    check_output("byte_ready_before_accept", 32'(bus.byte_ready), 32'd1);
    bus.byte_valid = 1'b1;
    bus.byte_in    = b;
    step();
    bus.byte_valid = 1'b0;
  endtask

  task automatic check_word(input string tag, input logic [31:0] word, input logic [3:0] mask);
    check_output({tag, "_valid"}, 32'(bus.word_valid), 32'd1);
    check_output({tag, "_data"}, bus.word_out, word);
    check_output({tag, "_mask"}, 32'(bus.word_mask), 32'(mask));
  endtask

  initial begin
    checks         = 0;
    errors         = 0;
    rst            = 1'b1;
    bus.byte_valid = 1'b0;
    bus.byte_in    = 8'h00;
    bus.flush      = 1'b0;
    bus.word_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    step();

    check_output("reset_word_valid", 32'(bus.word_valid), 32'd0);
    check_output("reset_word_out", bus.word_out, 32'h0);
    check_output("reset_word_mask", 32'(bus.word_mask), 32'd0);
    check_output("reset_byte_ready", 32'(bus.byte_ready), 32'd1);
    check_output("reset_busy", 32'(bus.busy), 32'd0);

    // Single word with the consumer always ready.
    bus.word_ready = 1'b1;
    apply_stimulus(8'h11);
    apply_stimulus(8'h22);
    apply_stimulus(8'h33);
    check_output("partial_no_word", 32'(bus.word_valid), 32'd0);
    check_output("partial_busy", 32'(bus.busy), 32'd1);
    apply_stimulus(8'h44);
    check_word("word_44332211", 32'h44332211, 4'b1111);
    step();
    check_output("drain_word_valid", 32'(bus.word_valid), 32'd0);
    check_output("drain_busy", 32'(bus.busy), 32'd0);

    // Back-to-back words without bubbles.
    for (int i = 1; i <= 8; i++) begin
      apply_stimulus(8'(i));
      if (i == 4) check_word("word_04030201", 32'h04030201, 4'b1111);
      if (i == 5) check_output("b2b_drained", 32'(bus.word_valid), 32'd0);
    end
    check_word("word_08070605", 32'h08070605, 4'b1111);
    step();
    check_output("b2b_idle", 32'(bus.word_valid), 32'd0);

    // Consumer stall: eight bytes absorbed, then byte_ready drops.
    bus.word_ready = 1'b0;
    for (int i = 1; i <= 8; i++) apply_stimulus(8'h10 + 8'(i));
    check_output("stall_byte_ready", 32'(bus.byte_ready), 32'd0);
    check_word("stall_first_word", 32'h14131211, 4'b1111);
    bus.byte_valid = 1'b1;
    bus.byte_in    = 8'h19;
    step();
    check_output("stall_still_blocked", 32'(bus.byte_ready), 32'd0);
    check_word("stall_word_stable", 32'h14131211, 4'b1111);
    bus.word_ready = 1'b1;
    step();
    bus.byte_valid = 1'b0;
    check_word("stall_second_word", 32'h18171615, 4'b1111);
    check_output("stall_released", 32'(bus.byte_ready), 32'd1);
    apply_stimulus(8'h19);
    check_output("stall_second_drained", 32'(bus.word_valid), 32'd0);
    apply_stimulus(8'h1A);
    apply_stimulus(8'h1B);
    apply_stimulus(8'h1C);
    check_word("stall_third_word", 32'h1C1B1A19, 4'b1111);
    step();

    // Flush together with a byte: the byte is part of the partial word.
    apply_stimulus(8'hAA);
    apply_stimulus(8'hBB);
    bus.flush = 1'b1;
    apply_stimulus(8'hCC);
    bus.flush = 1'b0;
    check_word("flush_partial", 32'h00CCBBAA, 4'b0111);
    bus.flush = 1'b1;
    step();
    bus.flush = 1'b0;
    check_output("empty_flush_no_word", 32'(bus.word_valid), 32'd0);
    check_output("empty_flush_busy", 32'(bus.busy), 32'd0);
    step();
    check_output("empty_flush_still_none", 32'(bus.word_valid), 32'd0);

    // Flush with the slot occupied parks in FLUSH until the slot frees.
    bus.word_ready = 1'b0;
    apply_stimulus(8'h21);
    apply_stimulus(8'h22);
    apply_stimulus(8'h23);
    apply_stimulus(8'h24);
    apply_stimulus(8'h31);
    apply_stimulus(8'h32);
    bus.flush = 1'b1;
    step();
    bus.flush = 1'b0;
    check_output("flush_pending_byte_ready", 32'(bus.byte_ready), 32'd0);
    check_output("flush_pending_busy", 32'(bus.busy), 32'd1);
    check_word("flush_pending_held", 32'h24232221, 4'b1111);
    bus.word_ready = 1'b1;
    step();
    check_word("flush_drained_partial", 32'h00003231, 4'b0011);
    check_output("flush_drained_byte_ready", 32'(bus.byte_ready), 32'd1);
    step();
    check_output("flush_idle_valid", 32'(bus.word_valid), 32'd0);
    check_output("flush_idle_busy", 32'(bus.busy), 32'd0);

    // Reset in STALL discards everything immediately.
    bus.word_ready = 1'b0;
    for (int i = 1; i <= 8; i++) apply_stimulus(8'h40 + 8'(i));
    check_output("pre_reset_stall", 32'(bus.byte_ready), 32'd0);
    check_output("pre_reset_valid", 32'(bus.word_valid), 32'd1);
    rst = 1'b1;
    #1;
    check_output("async_reset_valid", 32'(bus.word_valid), 32'd0);
    check_output("async_reset_word_out", bus.word_out, 32'h0);
    check_output("async_reset_busy", 32'(bus.busy), 32'd0);
    check_output("async_reset_byte_ready", 32'(bus.byte_ready), 32'd1);
    @(negedge clk);
    rst = 1'b0;
    step();
    bus.word_ready = 1'b1;
    apply_stimulus(8'h51);
    apply_stimulus(8'h52);
    apply_stimulus(8'h53);
    apply_stimulus(8'h54);
    check_word("post_reset_word", 32'h54535251, 4'b1111);
    step();
    check_output("post_reset_idle", 32'(bus.word_valid), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
